satatx_crcgen: RTL and testbench

//  Transmit-path CRC stage, directly upstream of the TX scrambler. Passes each
//  FIS Dword through unchanged and appends the 32-bit SATA CRC as an extra

---
 rtl/sata_pkg.sv | 39 +++
 rtl/satatx_crcgen.sv | 105 ++++++++++
 tb/tb_satatx_crcgen.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sata_pkg.sv
// Shared SATA CRC definitions: polynomial, seed, FSM state type and the
// bit-serial CRC step used by both the TX generator and the RX checker.
package sata_pkg;

    localparam logic [31:0] SATA_CRC_POLY = 32'h04c11db7;
    localparam logic [31:0] SATA_CRC_INIT = 32'h52325032;

    // DATA: passing payload through; CRC: payload done, CRC Dword pending.
    typedef enum logic {
        ST_DATA = 1'b0,
        ST_CRC  = 1'b1
    } crcgen_state_e;

    // One Dword of CRC update with an explicit polynomial. Data bit 31 is
    // shifted in first; no reflection and no final inversion.
    function automatic logic [31:0] sata_crc_step_poly(
        input logic [31:0] crc,
        input logic [31:0] data,
        input logic [31:0] poly
    );
        logic [31:0] c;
        logic        fb;
        c = crc;
        for (int k = 31; k >= 0; k--) begin
            fb = c[31] ^ data[k];
            c  = {c[30:0], 1'b0} ^ (fb ? poly : 32'h0);
        end
        return c;
    endfunction

    // One Dword of CRC update with the standard SATA polynomial.
    function automatic logic [31:0] sata_crc_step(
        input logic [31:0] crc,
        input logic [31:0] data
    );
        return sata_crc_step_poly(crc, data, SATA_CRC_POLY);
    endfunction

endpackage

// File: rtl/satatx_crcgen.sv
// TX CRC stage: forwards each FIS Dword unchanged and appends the SATA CRC
// as one extra Dword that carries TLAST. Sits directly before the scrambler.
//
// Handshake: a beat transfers on a rising edge where VALID && READY. A
// producer holds VALID and its payload stable until the transfer. The output
// register may load whenever it is empty or being drained this cycle
// ("free"); while it is stalled, its contents, the CRC and the state hold.
module satatx_crcgen
    import sata_pkg::*;
#(
    parameter logic [31:0] POLYNOMIAL   = SATA_CRC_POLY,
    parameter logic [31:0] INITIAL      = SATA_CRC_INIT,
    parameter bit          OPT_LOWPOWER = 1'b1
) (
    input  logic        S_AXI_ACLK,
    input  logic        S_AXI_ARESET,
    input  logic        S_AXIS_TVALID,
    output logic        S_AXIS_TREADY,
    input  logic [31:0] S_AXIS_TDATA,
    input  logic        S_AXIS_TLAST,
    output logic        M_AXIS_TVALID,
    input  logic        M_AXIS_TREADY,
    output logic [31:0] M_AXIS_TDATA,
    output logic        M_AXIS_TLAST
);

    crcgen_state_e state_q, state_d;
    logic [31:0]   crc_q, crc_d;
    logic          m_valid_q, m_valid_d;
    logic [31:0]   m_data_q, m_data_d;
    logic          m_last_q, m_last_d;
    logic          out_free;
    logic          s_accept;

    // Next-state, CRC update and output-register load.
    always_comb begin
        state_d       = state_q;
        crc_d         = crc_q;
        m_valid_d     = m_valid_q;
        m_data_d      = m_data_q;
        m_last_d      = m_last_q;
        out_free      = !m_valid_q || M_AXIS_TREADY;
        s_accept      = 1'b0;
        S_AXIS_TREADY = 1'b0;

        case (state_q)
            ST_DATA: begin
                S_AXIS_TREADY = out_free;
                s_accept      = S_AXIS_TVALID && out_free;
                if (s_accept) begin
                    m_valid_d = 1'b1;
                    m_data_d  = S_AXIS_TDATA;
                    m_last_d  = 1'b0;
                    crc_d     = sata_crc_step_poly(crc_q, S_AXIS_TDATA, POLYNOMIAL);
                    if (S_AXIS_TLAST) begin
                        state_d = ST_CRC;
                    end
                end else if (out_free) begin
                    m_valid_d = 1'b0;
                    if (OPT_LOWPOWER) begin
                        m_data_d = 32'h0;
                        m_last_d = 1'b0;
                    end
                end
            end
            ST_CRC: begin
                // The input is held off for this one slot so the CRC Dword
                // cannot be overtaken by the next frame's first Dword.
                if (out_free) begin
                    m_valid_d = 1'b1;
                    m_data_d  = crc_q;
                    m_last_d  = 1'b1;
                    crc_d     = INITIAL;
                    state_d   = ST_DATA;
                end
            end
            default: begin
                state_d = ST_DATA;
                crc_d   = INITIAL;
            end
        endcase
    end

    // State, CRC and output registers; reset drops any partial frame.
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            state_q   <= ST_DATA;
            crc_q     <= INITIAL;
            m_valid_q <= 1'b0;
            m_data_q  <= 32'h0;
            m_last_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            crc_q     <= crc_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_last_q  <= m_last_d;
        end
    end

    assign M_AXIS_TVALID = m_valid_q;
    assign M_AXIS_TDATA  = m_data_q;
    assign M_AXIS_TLAST  = m_last_q;

endmodule

// File: tb/tb_satatx_crcgen.sv
// Bench for satatx_crcgen: two instances (low-power on/off) share one input
// stream; each output stream is scored against a frame-level CRC model.
module tb_satatx_crcgen;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        s_valid = 1'b0;
    logic [31:0] s_data  = 32'h0;
    logic        s_last  = 1'b0;
    logic        m_ready = 1'b1;
    bit          rand_en = 1'b0;

    logic        s0_ready, m0_valid, m0_last;
    logic [31:0] m0_data;
    logic        s1_ready, m1_valid, m1_last;
    logic [31:0] m1_data;

    satatx_crcgen #(.OPT_LOWPOWER(1'b1)) dut_lp (
        .S_AXI_ACLK   (clk),
        .S_AXI_ARESET (rst),
        .S_AXIS_TVALID(s_valid),
        .S_AXIS_TREADY(s0_ready),
        .S_AXIS_TDATA (s_data),
        .S_AXIS_TLAST (s_last),
        .M_AXIS_TVALID(m0_valid),
        .M_AXIS_TREADY(m_ready),
        .M_AXIS_TDATA (m0_data),
        .M_AXIS_TLAST (m0_last)
    );

    satatx_crcgen #(.OPT_LOWPOWER(1'b0)) dut_np (
        .S_AXI_ACLK   (clk),
        .S_AXI_ARESET (rst),
        .S_AXIS_TVALID(s_valid),
        .S_AXIS_TREADY(s1_ready),
        .S_AXIS_TDATA (s_data),
        .S_AXIS_TLAST (s_last),
        .M_AXIS_TVALID(m1_valid),
        .M_AXIS_TREADY(m_ready),
        .M_AXIS_TDATA (m1_data),
        .M_AXIS_TLAST (m1_last)
    );

    // Downstream ready: always 1, or a 50% coin toss per cycle.
    always @(posedge clk) begin
        #1;
        m_ready = rand_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // ---------------- checking ----------------
    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Frame-level reference: treat the frame as one bit string, MSB of the
    // first Dword first, and run it through the CRC shift register.
    function automatic logic [31:0] model_crc(input logic [31:0] words[$]);
        bit          bits[$];
        logic [31:0] c;
        logic        msb;
        foreach (words[i]) begin
            for (int b = 31; b >= 0; b--) bits.push_back(words[i][b]);
        end
        c = 32'h52325032;
        foreach (bits[i]) begin
            msb = c[31];
            c   = {c[30:0], 1'b0};
            if (msb ^ bits[i]) c = c ^ 32'h04c11db7;
        end
        return c;
    endfunction

    // ---------------- scoreboard ----------------
    logic [32:0] exp_q[$];
    logic [32:0] exp1_q[$];
    int          beats    = 0;
    int          last_cnt = 0;
    bit          prev_stall0 = 1'b0;
    bit          prev_stall1 = 1'b0;
    logic [33:0] prev_out0, prev_out1;
    logic [32:0] e;

    always @(negedge clk) begin
        if (rst) begin
            prev_stall0 = 1'b0;
            prev_stall1 = 1'b0;
        end else begin
            if (prev_stall0) check("stall_hold_lp", 64'({m0_valid, m0_last, m0_data}), 64'(prev_out0));
            if (prev_stall1) check("stall_hold_np", 64'({m1_valid, m1_last, m1_data}), 64'(prev_out1));
            if (!m0_valid) check("lowpower_idle", 64'({m0_last, m0_data}), 64'h0);
            if (m0_valid && m_ready) begin
                if (exp_q.size() == 0) check("unexpected_beat_lp", 64'({m0_last, m0_data}), 64'hx);
                else begin
                    e = exp_q.pop_front();
                    check("out_beat_lp", 64'({m0_last, m0_data}), 64'(e));
                end
                beats++;
                if (m0_last) last_cnt++;
            end
            if (m1_valid && m_ready) begin
                if (exp1_q.size() == 0) check("unexpected_beat_np", 64'({m1_last, m1_data}), 64'hx);
                else begin
                    e = exp1_q.pop_front();
                    check("out_beat_np", 64'({m1_last, m1_data}), 64'(e));
                end
            end
            prev_stall0 = m0_valid && !m_ready;
            prev_stall1 = m1_valid && !m_ready;
            prev_out0   = {m0_valid, m0_last, m0_data};
            prev_out1   = {m1_valid, m1_last, m1_data};
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive_beat(input logic [31:0] d, input logic l);
        int n;
        bit acc;
        n = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        do begin
            @(negedge clk);
            acc = s0_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 2000);
        if (!acc) check("accept_timeout", 64'(acc), 64'h1);
    endtask

    task automatic send_frame(input logic [31:0] words[$], input bit gaps);
        logic [31:0] crc;
        crc = model_crc(words);
        foreach (words[i]) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                s_valid = 1'b0;
                @(posedge clk);
                #1;
            end
            exp_q.push_back({1'b0, words[i]});
            exp1_q.push_back({1'b0, words[i]});
            drive_beat(words[i], i == words.size() - 1);
        end
        exp_q.push_back({1'b1, crc});
        exp1_q.push_back({1'b1, crc});
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || exp1_q.size() != 0) && n < 5000) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("drain_empty", 64'(exp_q.size() + exp1_q.size()), 64'h0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [31:0] words[$];
        int          low_cnt;
        int          beats0;
        int          last0;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_m_valid", 64'(m0_valid), 64'h0);
        check("rst_m_data", 64'(m0_data), 64'h0);
        check("rst_m_last", 64'(m0_last), 64'h0);
        check("rst_s_ready", 64'(s0_ready), 64'h1);
        @(posedge clk);
        #1;

        // Fixed 3-Dword frame, sent twice back to back (each reseeds)
        words = {32'h00000000, 32'h11111111, 32'hffffffff};
        send_frame(words, 1'b0);
        send_frame(words, 1'b0);
        drain();

        // 1-Dword frame: two output beats, one-cycle input bubble
        beats0 = beats;
        words  = {32'h12345678};
        send_frame(words, 1'b0);
        low_cnt = 0;
        repeat (4) begin
            @(negedge clk);
            if (!s0_ready) low_cnt++;
        end
        check("one_dword_ready_low_cycles", 64'(low_cnt), 64'h1);
        drain();
        repeat (3) @(posedge clk);
        #1;
        check("one_dword_beats", 64'(beats - beats0), 64'h2);

        // Random backpressure over 100 random frames
        rand_en = 1'b1;
        last0   = last_cnt;
        for (int f = 0; f < 100; f++) begin
            words.delete();
            for (int i = 0; i < int'($urandom_range(1, 16)); i++) words.push_back($urandom);
            send_frame(words, 1'b1);
        end
        drain();
        rand_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("tlast_count", 64'(last_cnt - last0), 64'd100);

        // Reset on the 2nd Dword of a 4-Dword frame
        exp_q.push_back({1'b0, 32'ha5a5a5a5});
        exp1_q.push_back({1'b0, 32'ha5a5a5a5});
        drive_beat(32'ha5a5a5a5, 1'b0);
        s_data = 32'h5a5a5a5a;
        #2 rst = 1'b1;
        #1;
        check("midframe_rst_valid_lp", 64'(m0_valid), 64'h0);
        check("midframe_rst_valid_np", 64'(m1_valid), 64'h0);
        check("midframe_rst_data", 64'(m0_data), 64'h0);
        check("midframe_rst_last", 64'(m0_last), 64'h0);
        s_valid = 1'b0;
        exp_q.delete();
        exp1_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        words = {32'hdeadbeef};
        send_frame(words, 1'b0);
        drain();

        // Idle tail with low-power checks running in the scoreboard
        repeat (5) @(posedge clk);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
